// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART transmit scheduler:
//   - state_e        : transmitter FSM states (PARITY is only reachable when
//                      the design is built with UART_TX_PARITY_EN defined)
//   - frame constants: start/data bit counts and the data bit index width
//   - frame_bits()   : number of bit periods in one frame for a given stop
//                      bit count and parity setting
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int BIT_IDX_W  = 3;

  function automatic int frame_bits(input int stop_bits, input bit parity_en);
    return START_BITS + DATA_BITS + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous byte FIFO feeding the UART serializer. A push into a full
//   FIFO is accepted only when a pop happens on the same edge (the popped
//   slot is the one being overwritten). Pointers wrap modulo DEPTH, which
//   must be a power of two.
// Ports
//   clk      in   clock, all updates on posedge
//   rst      in   synchronous active-high reset (pointers and count only)
//   push_i   in   write request
//   pop_i    in   read request; ignored when empty
//   wdata_i  in   W-bit write data
//   rdata_o  out  head entry (valid while !empty_o)
//   count_o  out  entries stored, registered
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Buffers the core's one-cycle UART byte strobes in a FIFO and serializes
//   them on a single tx line at CLK_DIV clocks per bit, LSB first, 8N1/8N2.
//   Bytes arriving while the FIFO is full (and nothing is popped that edge)
//   are dropped and flagged by a one-cycle overflow pulse.
//   Optional feature macro: UART_TX_PARITY_EN -- inserts an even parity bit
//   after the data bits (8E1/8E2). Undefined by default.
// Ports
//   clock       in   single clock, posedge
//   reset       in   synchronous active-high reset
//   uart_in     in   [8]=byte strobe, [7:0]=byte
//   tx          out  serial line, idle high, registered
//   busy        out  frame in progress or FIFO non-empty
//   fifo_count  out  entries stored, registered
//   fifo_full   out  fifo_count == FIFO_DEPTH
//   overflow    out  one-cycle pulse after a dropped strobe
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [8:0]                    uart_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  // One counter times both single-bit states and the (possibly longer) stop.
  localparam int BAUD_W = $clog2(STOP_BITS * CLK_DIV);
  localparam logic [BAUD_W-1:0]    BAUD_BIT  = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0]    BAUD_STOP = BAUD_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX  = BIT_IDX_W'(DATA_BITS - 1);

  state_e                 state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BIT_IDX_W-1:0]   idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tx_q;
  logic                   ovf_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   strobe;
  logic                   pop_d;
  logic                   drop_d;

  assign strobe = uart_in[8];

  // Pop on an idle FSM, or on the last cycle of STOP so the next frame
  // starts with no idle gap.
  assign pop_d  = ~fifo_empty &
                  ((state_q == IDLE) | ((state_q == STOP) & (baud_q == '0)));
  assign drop_d = strobe & fifo_full & ~pop_d;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_BITS)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (strobe),
    .pop_i   (pop_d),
    .wdata_i (uart_in[7:0]),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (pop_d) begin
            shift_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
            state_q <= START;
            baud_q  <= BAUD_BIT;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_q == '0) begin
            state_q <= DATA;
            baud_q  <= BAUD_BIT;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              baud_q  <= BAUD_BIT;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              baud_q  <= BAUD_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q  <= idx_q + BIT_IDX_W'(1);
              baud_q <= BAUD_BIT;
              tx_q   <= shift_q[idx_q + BIT_IDX_W'(1)];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_q == '0) begin
            state_q <= STOP;
            baud_q  <= BAUD_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_q == '0) begin
            if (pop_d) begin
              shift_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^fifo_rdata;
`endif
              state_q <= START;
              baud_q  <= BAUD_BIT;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule
